// File: rtl/dma_cmd_sequencer.sv
// Command sequencer for a register-programmed DMA: a 4-deep command FIFO feeds an FSM
// that writes address, depth, width, set and start, then waits for the DMA to finish.
module dma_cmd_sequencer #(
   parameter int DATAWIDTH = 8,
   parameter int TIMEOUT   = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_set,
   input  logic [DATAWIDTH-1:0] cmd_addr,
   input  logic [DATAWIDTH-1:0] cmd_depth,
   input  logic [DATAWIDTH-1:0] cmd_width,
   input  logic                 err_clr,
   output logic                 dma_write,
   output logic [2:0]           dma_select,
   output logic [DATAWIDTH-1:0] dma_data,
   input  logic                 dma_finished,
   output logic                 seq_busy,
   output logic                 cmd_done,
   output logic [7:0]           cmd_count,
   output logic                 timeout_err
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef struct packed {
      logic [1:0]           set;
      logic [DATAWIDTH-1:0] addr;
      logic [DATAWIDTH-1:0] depth;
      logic [DATAWIDTH-1:0] width;
   } cmd_t;

   typedef enum logic [2:0] {
      S_IDLE, S_W_ADDR, S_W_DEPTH, S_W_WIDTH, S_W_SET, S_W_START, S_WAIT, S_HALT
   } state_t;

   cmd_t                 fifo_q [4];
   logic [1:0]           wr_ptr_q, rd_ptr_q;
   logic [2:0]           count_q, count_d;
   logic                 push, pop, fifo_empty;
   cmd_t                 head, cmd_in;

   state_t               state_q;
   logic [CNT_W-1:0]     tmo_cnt_q;
   logic [1:0]           cmd_set_q;
   logic [DATAWIDTH-1:0] cmd_depth_q, cmd_width_q;
   logic                 dma_write_q, cmd_done_q, timeout_err_q;
   logic [2:0]           dma_select_q;
   logic [DATAWIDTH-1:0] dma_data_q;
   logic [7:0]           cmd_count_q;

   assign cmd_in     = '{set: cmd_set, addr: cmd_addr, depth: cmd_depth, width: cmd_width};
   assign cmd_ready  = (count_q != 3'd4);
   assign fifo_empty = (count_q == 3'd0);
   assign push       = cmd_valid && cmd_ready;
   assign pop        = (state_q == S_IDLE) && !fifo_empty;
   assign head       = fifo_q[rd_ptr_q];
   assign count_d    = count_q + {2'b00, push} - {2'b00, pop};

   // FIFO storage carries no reset; occupancy alone decides what is valid
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= cmd_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
         count_q <= count_d;
      end
   end

   // Outputs are registered: each transition loads the values the next state presents
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         tmo_cnt_q     <= '0;
         cmd_set_q     <= '0;
         cmd_depth_q   <= '0;
         cmd_width_q   <= '0;
         dma_write_q   <= 1'b0;
         dma_select_q  <= '0;
         dma_data_q    <= '0;
         cmd_done_q    <= 1'b0;
         cmd_count_q   <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         dma_write_q  <= 1'b0;
         dma_select_q <= '0;
         dma_data_q   <= '0;
         cmd_done_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (!fifo_empty) begin
                  if (head.depth == '0 || head.width == '0) begin
                     cmd_done_q  <= 1'b1;
                     cmd_count_q <= cmd_count_q + 8'd1;
                  end else begin
                     cmd_set_q    <= head.set;
                     cmd_depth_q  <= head.depth;
                     cmd_width_q  <= head.width;
                     state_q      <= S_W_ADDR;
                     dma_write_q  <= 1'b1;
                     dma_select_q <= 3'd4;
                     dma_data_q   <= head.addr;
                  end
               end
            end
            S_W_ADDR: begin
               state_q      <= S_W_DEPTH;
               dma_write_q  <= 1'b1;
               dma_select_q <= 3'd0;
               dma_data_q   <= cmd_depth_q;
            end
            S_W_DEPTH: begin
               state_q      <= S_W_WIDTH;
               dma_write_q  <= 1'b1;
               dma_select_q <= 3'd1;
               dma_data_q   <= cmd_width_q;
            end
            S_W_WIDTH: begin
               state_q      <= S_W_SET;
               dma_write_q  <= 1'b1;
               dma_select_q <= 3'd2;
               dma_data_q   <= DATAWIDTH'(cmd_set_q);
            end
            S_W_SET: begin
               state_q      <= S_W_START;
               dma_write_q  <= 1'b1;
               dma_select_q <= 3'd3;
               dma_data_q   <= DATAWIDTH'(1);
            end
            S_W_START: begin
               state_q   <= S_WAIT;
               tmo_cnt_q <= '0;
            end
            S_WAIT: begin
               if (dma_finished) begin
                  cmd_done_q  <= 1'b1;
                  cmd_count_q <= cmd_count_q + 8'd1;
                  state_q     <= S_IDLE;
               end else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  timeout_err_q <= 1'b1;
                  state_q       <= S_HALT;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
               end
            end
            S_HALT: begin
               if (err_clr) begin
                  timeout_err_q <= 1'b0;
                  state_q       <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign dma_write   = dma_write_q;
   assign dma_select  = dma_select_q;
   assign dma_data    = dma_data_q;
   assign cmd_done    = cmd_done_q;
   assign cmd_count   = cmd_count_q;
   assign timeout_err = timeout_err_q;
   assign seq_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_dma_cmd_sequencer.sv
// Bench for dma_cmd_sequencer: directed scenarios plus random traffic, all outputs compared
// every cycle against a transaction-level model built from queues.
module tb_dma_cmd_sequencer;
   localparam int DW  = 8;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_set = '0;
   logic [DW-1:0] cmd_addr = '0, cmd_depth = '0, cmd_width = '0;
   logic          err_clr = 1'b0;
   logic          dma_write;
   logic [2:0]    dma_select;
   logic [DW-1:0] dma_data;
   logic          dma_finished = 1'b0;
   logic          seq_busy, cmd_done, timeout_err;
   logic [7:0]    cmd_count;

   dma_cmd_sequencer #(.DATAWIDTH(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_set(cmd_set), .cmd_addr(cmd_addr), .cmd_depth(cmd_depth), .cmd_width(cmd_width),
      .err_clr(err_clr), .dma_write(dma_write), .dma_select(dma_select), .dma_data(dma_data),
      .dma_finished(dma_finished), .seq_busy(seq_busy), .cmd_done(cmd_done),
      .cmd_count(cmd_count), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {logic [1:0] s; logic [7:0] a, d, w;} cmd_t;
   typedef struct packed {logic wr; logic [2:0] sel; logic [7:0] dat;} wr_t;
   cmd_t mq[$];
   wr_t  sched[$];
   int   mode = 0;            // 0 idle, 1 issuing writes, 2 waiting for DMA, 3 halted
   int   wcyc = 0;
   logic e_write = 0, e_done = 0, e_err = 0;
   logic [2:0] e_sel = 0;
   logic [7:0] e_data = 0, e_count = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete(); sched.delete();
         mode = 0; wcyc = 0;
         e_write = 0; e_sel = 0; e_data = 0; e_done = 0; e_err = 0; e_count = 0;
      end else begin : upd
         bit   do_push;
         cmd_t h;
         wr_t  w;
         do_push = cmd_valid && (mq.size() < 4);
         e_write = 0; e_sel = 0; e_data = 0; e_done = 0;
         case (mode)
            0: if (mq.size() > 0) begin
                  h = mq.pop_front();
                  if (h.d == 0 || h.w == 0) begin
                     e_done = 1; e_count++;
                  end else begin
                     sched.push_back(wr_t'{1'b1, 3'd4, h.a});
                     sched.push_back(wr_t'{1'b1, 3'd0, h.d});
                     sched.push_back(wr_t'{1'b1, 3'd1, h.w});
                     sched.push_back(wr_t'{1'b1, 3'd2, {6'd0, h.s}});
                     sched.push_back(wr_t'{1'b1, 3'd3, 8'd1});
                     mode = 1;
                  end
               end
            2: if (dma_finished) begin
                  e_done = 1; e_count++; mode = 0;
               end else begin
                  wcyc++;
                  if (wcyc == TMO) begin e_err = 1; mode = 3; end
               end
            3: if (err_clr) begin e_err = 0; mode = 0; end
            default: ;
         endcase
         if (mode == 1) begin
            if (sched.size() > 0) begin
               w = sched.pop_front();
               e_write = w.wr; e_sel = w.sel; e_data = w.dat;
            end else begin
               mode = 2; wcyc = 0;
            end
         end
         if (do_push) mq.push_back(cmd_t'{cmd_set, cmd_addr, cmd_depth, cmd_width});
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("dma_write", dma_write, e_write);
         chk("dma_select", dma_select, e_sel);
         chk("dma_data", dma_data, e_data);
         chk("cmd_done", cmd_done, e_done);
         chk("cmd_count", cmd_count, e_count);
         chk("timeout_err", timeout_err, e_err);
         chk("seq_busy", seq_busy, mode != 0);
         chk("cmd_ready", cmd_ready, mq.size() < 4);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      cmd_valid = 0; dma_finished = 0; err_clr = 0;
      #2 rst = 1;
      step(); step();
      rst = 0;
   endtask

   task automatic push_cmd(input logic [1:0] s, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] w);
      int n = 0;
      cmd_valid = 1; cmd_set = s; cmd_addr = a; cmd_depth = d; cmd_width = w;
      while (!cmd_ready && n < 50) begin step(); n++; end
      if (!cmd_ready) begin
         checks++; errors++;
         $display("FAIL push_wait actual=not_ready required=ready");
      end
      step();
      cmd_valid = 0;
   endtask

   task automatic finish_when_waiting();
      int n = 0;
      while (mode != 2 && n < 40) begin step(); n++; end
      if (mode != 2) begin
         checks++; errors++;
         $display("FAIL wait_state actual=mode%0d required=mode2", mode);
      end
      dma_finished = 1;
      step();
      dma_finished = 0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      step(); step();
      rst = 0;
      chk_en = 1;
      chk("reset_ready", cmd_ready, 1);
      chk("reset_count", cmd_count, 0);
      chk("reset_busy", seq_busy, 0);

      // single command: push in cycle 0
      push_cmd(2'd0, 8'h10, 8'd2, 8'd3);   // now in cycle 1
      step(); chk("c2_sel", dma_select, 4); chk("c2_data", dma_data, 8'h10); chk("c2_wr", dma_write, 1);
      step(); chk("c3_sel", dma_select, 0); chk("c3_data", dma_data, 2);
      step(); chk("c4_sel", dma_select, 1); chk("c4_data", dma_data, 3);
      step(); chk("c5_sel", dma_select, 2); chk("c5_data", dma_data, 0);
      step(); chk("c6_sel", dma_select, 3); chk("c6_data", dma_data, 1);
      step(); chk("c7_wr", dma_write, 0); chk("c7_busy", seq_busy, 1);
      repeat (5) step();
      dma_finished = 1;                    // cycle 12
      step(); dma_finished = 0;
      chk("c13_done", cmd_done, 1); chk("c13_count", cmd_count, 1);
      step(); chk("c14_done", cmd_done, 0); chk("c14_busy", seq_busy, 0);

      // zero-size commands
      do_reset();
      push_cmd(2'd1, 8'h20, 8'd0, 8'd5);
      step(); chk("zero_done", cmd_done, 1); chk("zero_count", cmd_count, 1); chk("zero_wr", dma_write, 0);
      push_cmd(2'd2, 8'h21, 8'd4, 8'd0);
      step(); chk("zero_w_done", cmd_done, 1); chk("zero_w_count", cmd_count, 2);

      // async reset during W_WIDTH
      do_reset();
      push_cmd(2'd1, 8'h33, 8'd7, 8'd9);
      repeat (3) step();
      chk("ww_wr", dma_write, 1); chk("ww_sel", dma_select, 1);
      #2 rst = 1;
      #1;
      chk("arst_wr", dma_write, 0); chk("arst_sel", dma_select, 0); chk("arst_data", dma_data, 0);
      chk("arst_busy", seq_busy, 0); chk("arst_ready", cmd_ready, 1);
      step(); step(); rst = 0;

      // FIFO full while held in WAIT
      do_reset();
      push_cmd(2'd0, 8'h40, 8'd1, 8'd1);
      repeat (6) step();
      for (int i = 0; i < 4; i++) push_cmd(2'(i % 3), 8'h50 + 8'(i), 8'd3, 8'd4);
      chk("full_ready", cmd_ready, 0);
      cmd_valid = 1; cmd_set = 2'd2; cmd_addr = 8'h60; cmd_depth = 8'd5; cmd_width = 8'd6;
      dma_finished = 1;
      step(); dma_finished = 0;
      push_cmd(2'd2, 8'h60, 8'd5, 8'd6);
      repeat (5) finish_when_waiting();
      chk("full_count", cmd_count, 6);

      // timeout, halt, err_clr
      do_reset();
      push_cmd(2'd1, 8'h70, 8'd2, 8'd2);
      repeat (13) step();
      chk("tmo_before", timeout_err, 0);
      step(); chk("tmo_set", timeout_err, 1); chk("tmo_busy", seq_busy, 1);
      push_cmd(2'd0, 8'h77, 8'd1, 8'd1);
      repeat (3) step();
      chk("halt_nowr", dma_write, 0); chk("halt_err", timeout_err, 1); chk("halt_count", cmd_count, 0);
      err_clr = 1; step(); err_clr = 0;
      chk("clr_err", timeout_err, 0);
      step(); chk("clr_sel", dma_select, 4); chk("clr_data", dma_data, 8'h77);
      finish_when_waiting();
      chk("clr_count", cmd_count, 1);

      // counter wrap
      do_reset();
      for (int i = 0; i < 255; i++) push_cmd(2'd0, 8'(i), 8'd0, 8'd1);
      repeat (3) step();
      chk("wrap_255", cmd_count, 255);
      push_cmd(2'd1, 8'hAA, 8'd1, 8'd2);
      finish_when_waiting();
      chk("wrap_done", cmd_done, 1); chk("wrap_0", cmd_count, 0);

      // random traffic
      do_reset();
      for (int i = 0; i < 2500; i++) begin
         cmd_valid    = ($urandom_range(0, 2) == 0);
         cmd_set      = 2'($urandom_range(0, 2));
         cmd_addr     = 8'($urandom_range(0, 255));
         cmd_depth    = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         cmd_width    = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         dma_finished = ($urandom_range(0, 4) == 0);
         err_clr      = ($urandom_range(0, 7) == 0);
         step();
      end
      cmd_valid = 0; dma_finished = 0; err_clr = 0;
      repeat (3) step();

      chk_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dma_cmd_sequencer.md
DMA_CMD_SEQUENCER -- requirements
Module: dma_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8, giving the width of DMA address, depth, width and data fields.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum WAIT cycles before abort.
REQ-003 The block SHALL have these ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_set  input  2  tensor set: 0 = A, 1 = B, 2 = X pop.
- cmd_addr  input  DATAWIDTH  start address.
- cmd_depth  input  DATAWIDTH  column dimension.
- cmd_width  input  DATAWIDTH  row dimension.
- err_clr  input  1  clears timeout_err and leaves HALT.
- dma_write  output  1  DMA register write strobe.
- dma_select  output  3  DMA register index.
- dma_data  output  DATAWIDTH  DMA register write data.
- dma_finished  input  1  DMA one-cycle completion pulse.
- seq_busy  output  1  high in any state except IDLE.
- cmd_done  output  1  one-cycle pulse per completed command.
- cmd_count  output  8  completed-command counter.
- timeout_err  output  1  sticky timeout flag.

Function
REQ-004 The block SHALL hold a 4-entry command FIFO of {set, addr, depth, width}.
- cmd_ready = !full.
- A push occurs when cmd_valid && cmd_ready.
- There is no bypass: an entry pushed in cycle N can be popped no earlier than cycle N+1.
REQ-005 The FSM SHALL have states IDLE, W_ADDR, W_DEPTH, W_WIDTH, W_SET, W_START, WAIT and HALT, all registered.
REQ-006 In IDLE with the FIFO non-empty, the block SHALL pop the head into a command register and enter W_ADDR on the next cycle.
- If the head has depth == 0 or width == 0, the block SHALL instead pop it, perform no DMA writes, pulse cmd_done next cycle, increment cmd_count, and stay in IDLE.
REQ-007 The write states SHALL each last exactly one cycle with dma_write = 1, in this order:
- W_ADDR: select 4, data addr.
- W_DEPTH: select 0, data depth.
- W_WIDTH: select 1, data width.
- W_SET: select 2, data zero-extended set.
- W_START: select 3, data 1.
REQ-008 Address, depth and width SHALL be written before start, because the DMA computes its final address on the start write.
REQ-009 Outside the write states, dma_write, dma_select and dma_data SHALL all be 0.
REQ-010 After W_START the block SHALL enter WAIT, clear its timeout counter and increment it once per WAIT cycle.
REQ-011 In WAIT, when dma_finished = 1, the block SHALL:
- pulse cmd_done for exactly the next cycle;
- increment cmd_count, wrapping modulo 256 (255 -> 0);
- return to IDLE.
REQ-012 A pending FIFO entry SHALL be popped in the cycle after the IDLE return, so back-to-back commands are spaced by one IDLE cycle.
REQ-013 In WAIT, if the counter reaches TIMEOUT with no dma_finished, the block SHALL set timeout_err and enter HALT.
- cmd_count does not change and cmd_done does not pulse.
- If dma_finished and the timeout occur in the same cycle, dma_finished takes priority.
REQ-014 In HALT the block SHALL issue no pops and no DMA writes; the FIFO SHALL still accept pushes while not full.
REQ-015 err_clr = 1 SHALL clear timeout_err and move the FSM from HALT to IDLE on the next cycle; err_clr has no effect in other states.
REQ-016 dma_finished pulses received outside WAIT SHALL be ignored.
REQ-017 When the FIFO is full, the block SHALL pop and push in the same cycle only if cmd_ready was high, i.e. never; when the FIFO is empty, a pop SHALL never occur.
REQ-018 The FIFO pointers SHALL wrap modulo 4, and occupancy SHALL be tracked with a 3-bit count.

Reset
REQ-019 While rst = 1, and immediately on its assertion, the block SHALL:
- set the FSM to IDLE and empty the FIFO;
- clear the timeout counter and the command register;
- drive dma_write, dma_select, dma_data, seq_busy, cmd_done, cmd_count and timeout_err to 0, and cmd_ready to 1.
REQ-020 A reset asserted mid-sequence (write states or WAIT) SHALL abort the command with no further DMA writes; any in-flight DMA transfer is not cancelled by this block.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Single command: push {set 0, addr 0x10, depth 2, width 3} into an empty FIFO at cycle 0 -> writes (4,0x10), (0,2), (3 on select 1), (select 2, data 0), (3,1) on cycles 2-6; dma_finished at cycle 12 -> cmd_done at 13, cmd_count = 1.
- FIFO full: push 5 commands while the FSM is held in WAIT -> cmd_ready low after 4 pushes; after a finish, cmd_ready returns high and the commands execute in push order.
- Zero-size command: depth = 0 -> no dma_write cycles, one cmd_done pulse, cmd_count increments.
- Timeout with TIMEOUT = 8 and no dma_finished -> timeout_err = 1 after 8 WAIT cycles, FSM in HALT, no pops; err_clr -> IDLE, next command issues.
- Async reset asserted during W_WIDTH -> dma_write drops to 0 before the next clock edge and all outputs match REQ-019.
- Counter wrap: 256 completed commands -> cmd_count = 0.
